// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the core_lapido execute-stage branch resolution unit:
// flag bit map, branch opcode encodings and FSM states.
package branch_resolve_unit_pkg;

  localparam int FLAG_W      = 6;
  localparam int FL_NEG      = 0;
  localparam int FL_ZERO     = 1;
  localparam int FL_CARRY    = 2;
  localparam int FL_NEGZERO  = 3;
  localparam int FL_TRUE     = 4;
  localparam int FL_OVERFLOW = 5;

  // Flush counter width covers the legal FLUSH_CYCLES range 1..15.
  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_JT   = 2'b01,
    BR_JF   = 2'b10,
    BR_J    = 2'b11
  } br_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: op + flags + cond_sel -> taken.
// Kept standalone so a future branch predictor can reuse it.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [1:0]        br_op_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [2:0]        cond_sel_i,
  output logic              taken_o
);

  logic [7:0] flags_ext;
  logic       cond_bit;

  // Selectors 6 and 7 land on the zero padding, so they read as 0.
  assign flags_ext = {{(8 - FLAG_W){1'b0}}, flags_i};
  assign cond_bit  = flags_ext[cond_sel_i];

  always_comb begin
    taken_o = 1'b0;
    case (br_op_i)
      BR_JT:   taken_o = cond_bit;
      BR_JF:   taken_o = ~cond_bit;
      BR_J:    taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: registered taken decision, fetch redirect,
// link register and multi-cycle flush sequencing. BRU_STATS_EN adds counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BRU_STATS_EN
  input  logic              stats_clr_i,
  output logic [STAT_W-1:0] taken_count_o,
  output logic [STAT_W-1:0] nottaken_count_o,
`endif
  input  logic              br_valid_i,
  input  logic [1:0]        br_op_i,
  input  logic              br_link_i,
  input  logic [2:0]        cond_sel_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [PC_W-1:0]   pc_plus1_i,
  input  logic [PC_W-1:0]   target_pc_i,
  input  logic              stall_i,
  output logic              branch_taken_o,
  output logic [PC_W-1:0]   redirect_pc_o,
  output logic              flush_o,
  output logic [PC_W-1:0]   ret_addr_o,
  output logic              busy_o
);

  bru_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken_q, taken_d;
  logic [PC_W-1:0]  redirect_q, redirect_d;
  logic [PC_W-1:0]  ret_q, ret_d;
  logic             cond_taken;
  logic             accept;

  branch_cond_eval u_cond_eval (
    .br_op_i    (br_op_i),
    .flags_i    (flags_i),
    .cond_sel_i (cond_sel_i),
    .taken_o    (cond_taken)
  );

  assign accept = br_valid_i && (state_q == IDLE) && !stall_i && (br_op_i != BR_NONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      taken_q    <= 1'b0;
      redirect_q <= '0;
      ret_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      ret_q      <= ret_d;
    end
  end

  // Wrong-path br_valid during FLUSH is ignored; the taken pulse always self-clears.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    taken_d    = 1'b0;
    redirect_d = redirect_q;
    ret_d      = ret_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (br_link_i) ret_d = pc_plus1_i;
          if (cond_taken) begin
            taken_d    = 1'b1;
            redirect_d = target_pc_i;
            state_d    = FLUSH;
            cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        if (!stall_i) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign branch_taken_o = taken_q;
  assign redirect_pc_o  = redirect_q;
  assign ret_addr_o     = ret_q;
  assign flush_o        = (state_q == FLUSH);
  assign busy_o         = (state_q != IDLE);

`ifdef BRU_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q, nottaken_cnt_q;

  // Saturating counters; a synchronous clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else if (stats_clr_i) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      if (accept && cond_taken && (taken_cnt_q != '1))
        taken_cnt_q <= taken_cnt_q + STAT_W'(1);
      if (accept && !cond_taken && (nottaken_cnt_q != '1))
        nottaken_cnt_q <= nottaken_cnt_q + STAT_W'(1);
    end
  end

  assign taken_count_o    = taken_cnt_q;
  assign nottaken_count_o = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus multi-cycle sequences.
// Exercises a FLUSH_CYCLES=2 and a FLUSH_CYCLES=1 instance; BRU_STATS_EN adds counter checks.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        brValid;
  logic [1:0]  brOp;
  logic        brLink;
  logic [2:0]  condSel;
  logic [5:0]  flags;
  logic [15:0] pcPlus1;
  logic [15:0] targetPc;
  logic        stall;

  logic        taken0, flush0, busy0, taken1, flush1, busy1;
  logic [15:0] redirect0, ret0, redirect1, ret1;
`ifdef BRU_STATS_EN
  logic        statsClr;
  logic [15:0] tcount0, ntcount0, tcount1, ntcount1;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic        link;
    logic [2:0]  sel;
    logic [5:0]  flg;
    logic [15:0] pc1;
    logic [15:0] tgt;
    logic        expTaken;
    logic [15:0] expRedirect;
    logic [15:0] expRet;
  } vec_t;

  vec_t vecs[10];

  branch_resolve_unit #(.PC_W(16), .FLUSH_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst),
`ifdef BRU_STATS_EN
    .stats_clr_i(statsClr), .taken_count_o(tcount0), .nottaken_count_o(ntcount0),
`endif
    .br_valid_i(brValid), .br_op_i(brOp), .br_link_i(brLink), .cond_sel_i(condSel),
    .flags_i(flags), .pc_plus1_i(pcPlus1), .target_pc_i(targetPc), .stall_i(stall),
    .branch_taken_o(taken0), .redirect_pc_o(redirect0), .flush_o(flush0),
    .ret_addr_o(ret0), .busy_o(busy0)
  );

  branch_resolve_unit #(.PC_W(16), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef BRU_STATS_EN
    .stats_clr_i(statsClr), .taken_count_o(tcount1), .nottaken_count_o(ntcount1),
`endif
    .br_valid_i(brValid), .br_op_i(brOp), .br_link_i(brLink), .cond_sel_i(condSel),
    .flags_i(flags), .pc_plus1_i(pcPlus1), .target_pc_i(targetPc), .stall_i(stall),
    .branch_taken_o(taken1), .redirect_pc_o(redirect1), .flush_o(flush1),
    .ret_addr_o(ret1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    brValid  = v.valid;
    brOp     = v.op;
    brLink   = v.link;
    condSel  = v.sel;
    flags    = v.flg;
    pcPlus1  = v.pc1;
    targetPc = v.tgt;
  endtask

  task automatic driveIdle();
    brValid = 1'b0;
    brOp    = 2'b00;
    brLink  = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic link, input logic [2:0] sel,
                       input logic [5:0] flg, input logic [15:0] pc1, input logic [15:0] tgt);
    brValid  = 1'b1;
    brOp     = op;
    brLink   = link;
    condSel  = sel;
    flags    = flg;
    pcPlus1  = pc1;
    targetPc = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    driveIdle();
    repeat (6) tick();
  endtask

  int fl0, fl1, tk;

  initial begin
    // Expected values below are worked by hand in row order; not-taken rows keep the prior redirect.
    vecs[0] = '{1'b1, 2'b01, 1'b0, 3'd1, 6'b000010, 16'h0010, 16'h0040, 1'b1, 16'h0040, 16'h0000};
    vecs[1] = '{1'b1, 2'b10, 1'b0, 3'd1, 6'b000010, 16'h0020, 16'h0080, 1'b0, 16'h0040, 16'h0000};
    vecs[2] = '{1'b1, 2'b01, 1'b1, 3'd6, 6'b111111, 16'h0101, 16'h0123, 1'b0, 16'h0040, 16'h0101};
    vecs[3] = '{1'b1, 2'b10, 1'b0, 3'd7, 6'b111111, 16'h0150, 16'h0200, 1'b1, 16'h0200, 16'h0101};
    vecs[4] = '{1'b1, 2'b11, 1'b1, 3'd0, 6'b000000, 16'h0011, 16'h0300, 1'b1, 16'h0300, 16'h0011};
    vecs[5] = '{1'b1, 2'b00, 1'b1, 3'd0, 6'b111111, 16'h0999, 16'h0400, 1'b0, 16'h0300, 16'h0011};
    vecs[6] = '{1'b1, 2'b01, 1'b0, 3'd5, 6'b100000, 16'h0222, 16'h0500, 1'b1, 16'h0500, 16'h0011};
    vecs[7] = '{1'b1, 2'b10, 1'b0, 3'd0, 6'b000001, 16'h0333, 16'h0600, 1'b0, 16'h0500, 16'h0011};
    vecs[8] = '{1'b1, 2'b01, 1'b0, 3'd4, 6'b010000, 16'h0444, 16'h0700, 1'b1, 16'h0700, 16'h0011};
    vecs[9] = '{1'b1, 2'b10, 1'b0, 3'd3, 6'b000000, 16'h0555, 16'h0800, 1'b1, 16'h0800, 16'h0011};

    rst = 1'b1;
    stall = 1'b0;
    condSel = 3'd0;
    flags = 6'd0;
    pcPlus1 = 16'd0;
    targetPc = 16'd0;
    driveIdle();
`ifdef BRU_STATS_EN
    statsClr = 1'b0;
`endif
    repeat (2) tick();
    checkOutput("reset.taken", {31'd0, taken0}, 32'd0);
    checkOutput("reset.flush", {31'd0, flush0}, 32'd0);
    checkOutput("reset.busy", {31'd0, busy0}, 32'd0);
    checkOutput("reset.redirect", {16'd0, redirect0}, 32'd0);
    checkOutput("reset.ret", {16'd0, ret0}, 32'd0);
    checkOutput("reset.dut1", {14'd0, redirect1, taken1, flush1, busy1, ret1 != 16'd0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("row%0d.taken", i), {31'd0, taken0}, {31'd0, vecs[i].expTaken});
      checkOutput($sformatf("row%0d.redirect", i), {16'd0, redirect0}, {16'd0, vecs[i].expRedirect});
      checkOutput($sformatf("row%0d.ret", i), {16'd0, ret0}, {16'd0, vecs[i].expRet});
      driveIdle();
      fl0 = int'(flush0);
      fl1 = int'(flush1);
      tk = 0;
      repeat (5) begin
        tick();
        fl0 += int'(flush0);
        fl1 += int'(flush1);
        tk  += int'(taken0);
      end
      checkOutput($sformatf("row%0d.flushCycles", i), fl0, vecs[i].expTaken ? 32'd2 : 32'd0);
      checkOutput($sformatf("row%0d.flushCycles1", i), fl1, vecs[i].expTaken ? 32'd1 : 32'd0);
      checkOutput($sformatf("row%0d.pulseLen", i), tk, 32'd0);
      checkOutput($sformatf("row%0d.busyEnd", i), {31'd0, busy0}, 32'd0);
    end

`ifdef BRU_STATS_EN
    checkOutput("stats.taken", {16'd0, tcount0}, 32'd6);
    checkOutput("stats.nottaken", {16'd0, ntcount0}, 32'd3);
    @(negedge clk);
    drive(2'b11, 1'b0, 3'd0, 6'd0, 16'h0000, 16'h0900);
    statsClr = 1'b1;
    tick();
    checkOutput("stats.clrTaken", {16'd0, tcount0}, 32'd0);
    checkOutput("stats.clrNottaken", {16'd0, ntcount1}, 32'd0);
    checkOutput("stats.clrPulse", {31'd0, taken0}, 32'd1);
    statsClr = 1'b0;
    settle();
    @(negedge clk);
    drive(2'b01, 1'b0, 3'd2, 6'b000000, 16'h0000, 16'h0910);
    tick();
    checkOutput("stats.afterClr", {tcount0, ntcount0}, {16'd0, 16'd1});
    settle();
`endif

    // Not-taken followed immediately by an unconditional branch.
    @(negedge clk);
    drive(2'b10, 1'b0, 3'd1, 6'b000010, 16'h0000, 16'h0C00);
    tick();
    checkOutput("b2b.ntTaken", {31'd0, taken0}, 32'd0);
    checkOutput("b2b.ntBusy", {31'd0, busy0}, 32'd0);
    drive(2'b11, 1'b0, 3'd1, 6'b000010, 16'h0000, 16'h0C10);
    tick();
    checkOutput("b2b.taken", {31'd0, taken0}, 32'd1);
    checkOutput("b2b.redirect", {16'd0, redirect0}, 32'h0C10);
    settle();

    // A stalled IDLE cycle must not sample the branch.
    @(negedge clk);
    drive(2'b11, 1'b0, 3'd0, 6'd0, 16'h0000, 16'h0D00);
    stall = 1'b1;
    tick();
    checkOutput("idleStall.taken", {30'd0, taken0, busy0}, 32'd0);
    stall = 1'b0;
    tick();
    checkOutput("idleStall.accept", {31'd0, taken0}, 32'd1);
    checkOutput("idleStall.redirect", {16'd0, redirect0}, 32'h0D00);
    settle();

    // Link, then a wrong-path branch during FLUSH is ignored.
    @(negedge clk);
    drive(2'b11, 1'b1, 3'd0, 6'd0, 16'h0044, 16'h0E00);
    tick();
    checkOutput("link.ret", {16'd0, ret0}, 32'h0044);
    checkOutput("link.taken", {31'd0, taken0}, 32'd1);
    drive(2'b11, 1'b1, 3'd0, 6'd0, 16'h0055, 16'h0E80);
    tick();
    checkOutput("ignore.taken", {31'd0, taken0}, 32'd0);
    checkOutput("ignore.ret", {16'd0, ret0}, 32'h0044);
    checkOutput("ignore.redirect", {16'd0, redirect0}, 32'h0E00);
    checkOutput("ignore.flush", {31'd0, flush0}, 32'd1);
    settle();

    // Three stall cycles stretch FLUSH from 2 to 5 cycles.
    @(negedge clk);
    drive(2'b11, 1'b0, 3'd0, 6'd0, 16'h0000, 16'h0A00);
    tick();
    driveIdle();
    stall = 1'b1;
    fl0 = int'(flush0);
    fl1 = int'(flush1);
    tk = int'(taken0);
    repeat (3) begin
      tick();
      fl0 += int'(flush0);
      fl1 += int'(flush1);
      tk  += int'(taken0);
    end
    stall = 1'b0;
    repeat (4) begin
      tick();
      fl0 += int'(flush0);
      fl1 += int'(flush1);
      tk  += int'(taken0);
    end
    checkOutput("stall.flushCycles", fl0, 32'd5);
    checkOutput("stall.flushCycles1", fl1, 32'd4);
    checkOutput("stall.pulseLen", tk, 32'd1);
    settle();

    // Asynchronous reset in the middle of a flush.
    @(negedge clk);
    drive(2'b11, 1'b1, 3'd0, 6'd0, 16'h0066, 16'h0B00);
    tick();
    driveIdle();
    checkOutput("midFlush.pre", {30'd0, flush0, taken0}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midFlush.taken", {31'd0, taken0}, 32'd0);
    checkOutput("midFlush.flushBusy", {30'd0, flush0, busy0}, 32'd0);
    checkOutput("midFlush.redirect", {16'd0, redirect0}, 32'd0);
    checkOutput("midFlush.ret", {16'd0, ret0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch resolution for core_lapido.
- Evaluates pending jump/branch instructions against the registered 6-bit flag vector and produces a one-cycle `branch_taken` pulse. That pulse clears the flag register and drives the fetch redirect target.
- Sequences a multi-cycle pipeline flush so younger wrong-path instructions are squashed before new branches are accepted.

Parameters:
- PC_W, 16, program-counter / target width in bits
- FLUSH_CYCLES, 2, cycles `flush` stays asserted after a taken branch (legal range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- br_valid  in  1  branch instruction present in execute this cycle
- br_op  in  2  00 none, 01 jump-if-true, 10 jump-if-false, 11 unconditional
- br_link  in  1  save return address (jal-style)
- cond_sel  in  3  flag index 0..5 tested by conditional ops
- flags  in  6  current registered flag vector
- pc_plus1  in  PC_W  address of the following instruction
- target_pc  in  PC_W  branch destination
- stall  in  1  pipeline stall; freezes acceptance and the flush counter
- branch_taken  out  1  one-cycle pulse; clears the flag register
- redirect_pc  out  PC_W  fetch target, valid while branch_taken=1
- flush  out  1  squash younger stages
- ret_addr  out  PC_W  last linked return address
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - branch_taken=0, flush=0, busy=0
  - redirect_pc=0, ret_addr=0
  - state=IDLE, flush counter=0
- Flag bit map (package constants):
  - 0 NEG, 1 ZERO, 2 CARRY, 3 NEGZERO, 4 TRUE, 5 OVERFLOW
- cond_sel 6 or 7: condition bit reads 0.
- Branch is accepted when br_valid=1, state=IDLE, stall=0 and br_op!=00.
- Decision:
  - 01: taken if flags[cond_sel]=1
  - 10: taken if flags[cond_sel]=0
  - 11: always taken
- Latency: decision is registered. At edge N accept → from edge N:
  - branch_taken=1 and redirect_pc=target_pc for exactly one cycle
  - flush=1
  - state moves to FLUSH with counter=FLUSH_CYCLES-1
- Not-taken branch: no output change and state stays IDLE. There is no penalty.
- br_link=1 on any accepted branch (taken or not) loads ret_addr<=pc_plus1 at the accept edge.
- FLUSH state:
  - flush=1 and busy=1
  - br_valid is ignored, because those instructions are wrong-path
  - each non-stall cycle decrements the counter; when counter=0 and stall=0, return to IDLE with flush=0 at that edge
  - stall=1 holds the counter and flush; branch_taken still drops after one cycle
- FLUSH_CYCLES=1: FLUSH lasts exactly one cycle.
- br_valid with stall=1 in IDLE: not sampled; the instruction re-presents next cycle.
- Reset asserted mid-flush: immediate return to reset values; any in-progress redirect is abandoned.
- redirect_pc holds its last value when branch_taken=0.

Optional Feature:
- BRU_STATS_EN, when defined, adds:
  - outputs taken_count[15:0] and nottaken_count[15:0]
  - each counter increments per accepted taken / not-taken branch
  - counters saturate at 16'hFFFF and are reset to 0 by rst
  - input stats_clr: synchronous clear; it wins over a simultaneous increment
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - flag index constants FL_NEG..FL_OVERFLOW and flag width (6)
  - br_op encodings BR_NONE/BR_JT/BR_JF/BR_J
  - state enum IDLE/FLUSH
- Sub-module: one natural sub-module, `branch_cond_eval`, a combinational op+flags+cond_sel → taken evaluator shared with a future predictor.
- The FSM, flush counter and link register stay in the top.

Test Plan:
- Reset mid-flush: rst during FLUSH → all outputs 0 and state IDLE immediately, asynchronously.
- Conditional taken: br_op=01, cond_sel=1, flags=6'b000010, target_pc=16'h0040 → next cycle branch_taken=1 for 1 cycle, redirect_pc=0040, flush=1 for 2 cycles, busy=1 for 2 cycles.
- Conditional not taken: br_op=10, cond_sel=1, flags=6'b000010 → branch_taken stays 0, busy stays 0. A back-to-back br_op=11 next cycle is accepted.
- Link and ignore during flush:
  - br_op=11, br_link=1, pc_plus1=16'h0011 → ret_addr=0011
  - a second br_valid during FLUSH produces no pulse and ret_addr is unchanged
- Stall extends flush: taken branch, then stall=1 for 3 cycles during FLUSH → flush high 5 cycles total; branch_taken still one cycle.
- Stats with BRU_STATS_EN:
  - 3 taken and 2 not-taken → counts 3/2
  - preload taken_count=16'hFFFF then a taken branch → stays FFFF
  - stats_clr together with a taken branch → 0
